// File: rtl/boot_loader_ctrl_if.sv
// rtl/boot_loader_ctrl_if.sv - host word stream between loader host and boot_loader_ctrl
interface boot_loader_ctrl_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  ld_valid;
  logic [DATA_WIDTH-1:0] ld_data;
  logic                  ld_ready;

  modport master (output ld_valid, output ld_data, input  ld_ready);
  modport slave  (input  ld_valid, input  ld_data, output ld_ready);
endinterface

// File: rtl/boot_loader_ctrl.sv
// rtl/boot_loader_ctrl.sv - holds the CPU in reset, streams a program image into memory, then releases the CPU
module boot_loader_ctrl #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int RESET_HOLD = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] load_base,
  input  logic [ADDR_WIDTH-1:0] load_len,
  boot_loader_ctrl_if.slave     ld,
  input  logic [ADDR_WIDTH-1:0] cpu_address,
  input  logic                  cpu_we,
  input  logic [DATA_WIDTH-1:0] cpu_data_out,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_data,
  output logic                  cpu_reset,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] word_count
);

  localparam logic [1:0] S_WAIT = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;
  localparam logic [1:0] S_RUN  = 2'd3;

  localparam int HW = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
  localparam logic [HW-1:0] HOLD_INIT = HW'(RESET_HOLD - 1);

  logic [1:0]            state;
  logic [ADDR_WIDTH-1:0] base;
  logic [ADDR_WIDTH-1:0] len;
  logic [HW-1:0]         hold_cnt;
  logic [ADDR_WIDTH-1:0] wc_next;

  assign wc_next = word_count + ADDR_WIDTH'(1);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= S_WAIT;
      base       <= '0;
      len        <= '0;
      word_count <= '0;
      hold_cnt   <= '0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_WAIT, S_RUN: begin
          if (start) begin
            base       <= load_base;
            len        <= load_len;
            word_count <= '0;
            // An empty image still pulses cpu_reset for the full hold time
            if (load_len == '0) begin
              state    <= S_HOLD;
              hold_cnt <= HOLD_INIT;
            end else begin
              state <= S_LOAD;
            end
          end
        end
        S_LOAD: begin
          if (ld.ld_valid) begin
            word_count <= wc_next;
            if (wc_next == len) begin
              state    <= S_HOLD;
              hold_cnt <= HOLD_INIT;
            end
          end
        end
        S_HOLD: begin
          if (hold_cnt == '0) begin
            state <= S_RUN;
            done  <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt - HW'(1);
          end
        end
        default: state <= S_WAIT;
      endcase
    end
  end

  assign cpu_reset = (state != S_RUN);
  assign busy      = (state == S_LOAD) || (state == S_HOLD);
  assign ld.ld_ready = (state == S_LOAD);

  // The loader owns the port only in LOAD; elsewhere the CPU drives it but may write only in RUN
  always_comb begin
    mem_address = cpu_address;
    mem_data    = cpu_data_out;
    mem_we      = 1'b0;
    if (state == S_LOAD) begin
      mem_address = base + word_count;
      mem_data    = ld.ld_data;
      mem_we      = ld.ld_valid;
    end else if (state == S_RUN) begin
      mem_we = cpu_we;
    end
  end

endmodule

// File: tb/tb_boot_loader_ctrl.sv
// tb/tb_boot_loader_ctrl.sv - directed self-checking bench for boot_loader_ctrl
module tb_boot_loader_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] load_base;
  logic [15:0] load_len;
  logic [15:0] cpu_address;
  logic        cpu_we;
  logic [31:0] cpu_data_out;
  logic [15:0] mem_address;
  logic        mem_we;
  logic [31:0] mem_data;
  logic        cpu_reset;
  logic        busy;
  logic        done;
  logic [15:0] word_count;

  int checks = 0;
  int errors = 0;

  boot_loader_ctrl_if #(.DATA_WIDTH(32)) ld_if ();

  boot_loader_ctrl #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .RESET_HOLD(4)) dut (
    .clock(clock), .reset(reset), .start(start),
    .load_base(load_base), .load_len(load_len),
    .ld(ld_if.slave),
    .cpu_address(cpu_address), .cpu_we(cpu_we), .cpu_data_out(cpu_data_out),
    .mem_address(mem_address), .mem_we(mem_we), .mem_data(mem_data),
    .cpu_reset(cpu_reset), .busy(busy), .done(done), .word_count(word_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  // From the negedge right after the last accept: three more HOLD cycles, then the done cycle
  task automatic hold_then_run(input string tag);
    for (int k = 1; k <= 3; k++) begin
      step();
      check({tag, "_hold_rst"}, cpu_reset, 1'b1);
      check({tag, "_hold_done"}, done, 1'b0);
      check({tag, "_hold_we"}, mem_we, 1'b0);
    end
    step();
    check({tag, "_done"}, done, 1'b1);
    check({tag, "_run_rst"}, cpu_reset, 1'b0);
    check({tag, "_run_busy"}, busy, 1'b0);
  endtask

  logic [31:0] words [4];
  logic        vpat  [5];
  logic [15:0] wcexp [5];
  logic [15:0] adexp [5];
  logic [15:0] wrap  [4];
  int          pulses;

  initial begin
    words = '{32'h40000005, 32'h10000006, 32'h70000007, 32'h80000002};
    vpat  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    wcexp = '{16'd1, 16'd1, 16'd1, 16'd2, 16'd3};
    adexp = '{16'h0100, 16'h0101, 16'h0101, 16'h0101, 16'h0102};
    wrap  = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};

    reset = 1'b0; start = 1'b0; load_base = '0; load_len = '0;
    ld_if.ld_valid = 1'b0; ld_if.ld_data = '0;
    cpu_address = 16'h1234; cpu_we = 1'b1; cpu_data_out = 32'hAAAA5555;

    // Reset state
    @(negedge clock);
    check("rst_cpu_reset", cpu_reset, 1'b1);
    check("rst_ld_ready", ld_if.ld_ready, 1'b0);
    check("rst_mem_we", mem_we, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_wc", word_count, 16'h0);
    check("rst_addr", mem_address, 16'h1234);
    check("rst_data", mem_data, 32'hAAAA5555);
    reset = 1'b1; cpu_we = 1'b0;
    step();
    check("wait_we", mem_we, 1'b0);

    // Four-word load at base 0
    start = 1'b1; load_base = 16'h0000; load_len = 16'd4;
    step();
    start = 1'b0;
    check("l4_busy", busy, 1'b1);
    check("l4_ready", ld_if.ld_ready, 1'b1);
    check("l4_wc0", word_count, 16'h0);
    for (int i = 0; i < 4; i++) begin
      ld_if.ld_valid = 1'b1; ld_if.ld_data = words[i];
      #1;
      check("l4_we", mem_we, 1'b1);
      check("l4_addr", mem_address, 16'(i));
      check("l4_data", mem_data, words[i]);
      step();
    end
    ld_if.ld_valid = 1'b0; cpu_we = 1'b1;
    #1;
    check("l4_hold_ready", ld_if.ld_ready, 1'b0);
    check("l4_hold_we", mem_we, 1'b0);
    check("l4_wc", word_count, 16'd4);
    check("l4_hold_busy", busy, 1'b1);
    hold_then_run("l4");
    cpu_address = 16'h0010; cpu_data_out = 32'hCAFEF00D;
    #1;
    check("run_we", mem_we, 1'b1);
    check("run_addr", mem_address, 16'h0010);
    check("run_data", mem_data, 32'hCAFEF00D);
    step();
    check("run_done_low", done, 1'b0);

    // Zero-length start from RUN
    start = 1'b1; load_base = 16'h0055; load_len = 16'd0;
    step();
    start = 1'b0;
    check("z_rst", cpu_reset, 1'b1);
    check("z_busy", busy, 1'b1);
    check("z_we", mem_we, 1'b0);
    check("z_ready", ld_if.ld_ready, 1'b0);
    check("z_wc", word_count, 16'h0);
    hold_then_run("z");
    check("z_run_we", mem_we, 1'b1);
    cpu_we = 1'b0;
    step();

    // Stalling host
    start = 1'b1; load_base = 16'h0100; load_len = 16'd3;
    step();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      ld_if.ld_valid = vpat[i]; ld_if.ld_data = 32'h5000 + 32'(i);
      #1;
      check("st_we", mem_we, vpat[i]);
      check("st_addr", mem_address, adexp[i]);
      step();
      check("st_wc", word_count, wcexp[i]);
    end
    ld_if.ld_valid = 1'b0;
    check("st_hold_busy", busy, 1'b1);
    check("st_hold_ready", ld_if.ld_ready, 1'b0);
    hold_then_run("st");
    step();

    // Address wrap with ignored start pulses during LOAD and HOLD
    start = 1'b1; load_base = 16'hFFFE; load_len = 16'd4;
    step();
    for (int i = 0; i < 4; i++) begin
      start = (i == 1) || (i == 3);
      load_base = 16'h1234; load_len = 16'd2;
      ld_if.ld_valid = 1'b1; ld_if.ld_data = 32'h1000 + 32'(i);
      #1;
      check("wr_we", mem_we, 1'b1);
      check("wr_addr", mem_address, wrap[i]);
      step();
    end
    ld_if.ld_valid = 1'b0;
    check("wr_wc", word_count, 16'd4);
    pulses = 0;
    for (int k = 0; k < 8; k++) begin
      start = (k < 2);
      #1;
      if (done) pulses++;
      step();
    end
    start = 1'b0;
    check("wr_done_pulses", pulses, 1);
    check("wr_wc_final", word_count, 16'd4);
    check("wr_run", cpu_reset, 1'b0);

    // Reset mid-load after 3 of 8 words
    start = 1'b1; load_base = 16'h0200; load_len = 16'd8;
    step();
    start = 1'b0;
    ld_if.ld_valid = 1'b1;
    repeat (3) step();
    check("mr_wc3", word_count, 16'd3);
    reset = 1'b0;
    #1;
    check("mr_wc", word_count, 16'h0);
    check("mr_rst", cpu_reset, 1'b1);
    check("mr_we", mem_we, 1'b0);
    check("mr_ready", ld_if.ld_ready, 1'b0);
    check("mr_busy", busy, 1'b0);
    step();
    reset = 1'b1;
    start = 1'b1; load_base = 16'h0300; load_len = 16'd8;
    step();
    start = 1'b0;
    check("mr_new_wc0", word_count, 16'h0);
    #1;
    check("mr_new_addr", mem_address, 16'h0300);
    check("mr_new_we", mem_we, 1'b1);
    step();
    check("mr_new_wc1", word_count, 16'd1);
    ld_if.ld_valid = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
